// File: rtl/galvo_pkg.sv
// Shared XY2-100 definitions for the galvo receive path: frame constants,
// receiver FSM encoding and the frame parity helper.
`timescale 1ns/1ps
package galvo_pkg;

  localparam int         XY2_FRAME_LEN = 20;
  localparam logic [2:0] XY2_HDR_STD   = 3'b001;
  localparam logic       XY2_HDR_ENH   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_CHECK  = 2'd2,
    ST_RESYNC = 2'd3
  } xy2_state_t;

  // 1 when the frame holds an even number of ones.
  function automatic logic xy2_even_parity(input logic [XY2_FRAME_LEN-1:0] frame);
    return ~^frame;
  endfunction

endpackage

// File: rtl/xy2_rx_multi_if.sv
// XY2 line bundle plus the setpoint/status publication bus of xy2_rx_multi.
`timescale 1ns/1ps
interface xy2_rx_multi_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 16
);
  import galvo_pkg::*;

  // Handshake: sp_valid[c] is a one-cycle strobe with no ready; setpoint
  // channel c is new on that cycle and holds until the next strobe.
  logic                     xy_clk;
  logic                     xy_sync;
  logic [NUM_CH-1:0]        xy_data;
  logic [15:0]              status_word;
  logic                     xy_status;
  logic [NUM_CH*DATA_W-1:0] setpoint;
  logic [NUM_CH-1:0]        sp_valid;
  logic                     link_ok;
  logic [15:0]              frame_err_cnt;
  logic [15:0]              parity_err_cnt;
  xy2_state_t               dbg_state;

  modport master (
    output xy_clk, xy_sync, xy_data, status_word,
    input  xy_status, setpoint, sp_valid, link_ok, frame_err_cnt, parity_err_cnt, dbg_state
  );

  modport slave (
    input  xy_clk, xy_sync, xy_data, status_word,
    output xy_status, setpoint, sp_valid, link_ok, frame_err_cnt, parity_err_cnt, dbg_state
  );

endinterface

// File: rtl/xy2_sync_edge.sv
// Two-flop synchroniser for one asynchronous XY2 line, with single-cycle
// rise/fall pulses derived from the synchronised level.
`timescale 1ns/1ps
module xy2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q    = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/xy2_rx_multi.sv
// Multi-channel XY2-100(-E) command receiver with link supervision.
// Optional status return channel enabled by defining XY2_STATUS_TX_EN.
`timescale 1ns/1ps
module xy2_rx_multi
  import galvo_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 400
) (
  input  logic            clk_ref,
  input  logic            sys_rstn,
  xy2_rx_multi_if.slave   bus
);

  localparam int HDR_W  = XY2_FRAME_LEN - 1 - DATA_W;
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [HDR_W-1:0]  HDR_EXP = (DATA_W == 16) ? HDR_W'(XY2_HDR_STD) : HDR_W'(XY2_HDR_ENH);
  localparam logic [DATA_W-1:0] SP_RST  = {1'b1, {(DATA_W-1){1'b0}}};

  logic clk_q, clk_rise, clk_fall;
  logic sync_q, sync_rise, sync_fall;
  logic [NUM_CH-1:0] data_q, data_rise, data_fall;
  logic unused_sig;

  xy2_sync_edge u_clk  (.clk(clk_ref), .rst_n(sys_rstn), .din(bus.xy_clk),
                        .q(clk_q), .rise(clk_rise), .fall(clk_fall));
  xy2_sync_edge u_sync (.clk(clk_ref), .rst_n(sys_rstn), .din(bus.xy_sync),
                        .q(sync_q), .rise(sync_rise), .fall(sync_fall));
  for (genvar c = 0; c < NUM_CH; c++) begin : g_data
    xy2_sync_edge u_data (.clk(clk_ref), .rst_n(sys_rstn), .din(bus.xy_data[c]),
                          .q(data_q[c]), .rise(data_rise[c]), .fall(data_fall[c]));
  end

  xy2_state_t state, next_state;
  logic [4:0]  bit_cnt;
  logic [XY2_FRAME_LEN-1:0] shreg [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] sp_r;
  logic [NUM_CH-1:0] sp_valid_r, ch_ok;
  logic [1:0]  nfail;
  logic        link_ok_r, armed, start, shift_en, frame_err, timeout;
  logic [15:0] frame_cnt, parity_cnt;
  logic [IDLE_W-1:0] idle_cnt;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign timeout = (idle_cnt == IDLE_W'(TIMEOUT_CYC)) && !clk_fall;

  always_comb begin
    next_state = state;
    start      = 1'b0;
    shift_en   = 1'b0;
    frame_err  = 1'b0;
    case (state)
      ST_IDLE: if (clk_fall && sync_q && armed) begin
        next_state = ST_SHIFT;
        start      = 1'b1;
        shift_en   = 1'b1;
      end
      ST_SHIFT: if (clk_fall) begin
        shift_en = 1'b1;
        if (!sync_q) begin
          if (bit_cnt == 5'd19) next_state = ST_CHECK;
          else begin
            frame_err  = 1'b1;
            next_state = ST_IDLE;
          end
        end else if (bit_cnt == 5'd19) begin
          frame_err  = 1'b1;
          next_state = ST_RESYNC;
        end
      end
      ST_CHECK:  next_state = ST_IDLE;
      ST_RESYNC: if (clk_fall && !sync_q) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
    if (timeout) next_state = ST_IDLE;
  end

  always_comb begin
    ch_ok = '0;
    nfail = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_ok[c] = (shreg[c][XY2_FRAME_LEN-1 -: HDR_W] == HDR_EXP) && xy2_even_parity(shreg[c]);
      if (!ch_ok[c]) nfail = nfail + 2'd1;
    end
  end

  always_ff @(posedge clk_ref or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      idle_cnt <= '0;
      armed    <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) shreg[c] <= '0;
    end else begin
      state <= next_state;
      if (clk_fall) idle_cnt <= '0;
      else if (idle_cnt != IDLE_W'(TIMEOUT_CYC)) idle_cnt <= idle_cnt + 1'b1;
      // A frame start only counts once a sync-low bit has been seen since reset.
      if (clk_fall && !sync_q) armed <= 1'b1;
      if (shift_en) begin
        bit_cnt <= start ? 5'd1 : bit_cnt + 5'd1;
        for (int c = 0; c < NUM_CH; c++) shreg[c] <= {shreg[c][XY2_FRAME_LEN-2:0], data_q[c]};
      end
    end
  end

  always_ff @(posedge clk_ref or negedge sys_rstn) begin
    if (!sys_rstn) begin
      sp_r       <= {NUM_CH{SP_RST}};
      sp_valid_r <= '0;
      link_ok_r  <= 1'b0;
      frame_cnt  <= '0;
      parity_cnt <= '0;
    end else begin
      sp_valid_r <= '0;
      if (state == ST_CHECK) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_ok[c]) begin
            sp_r[c*DATA_W +: DATA_W] <= shreg[c][DATA_W:1];
            sp_valid_r[c]            <= 1'b1;
          end
        end
        if (nfail != 2'd0) begin
          parity_cnt <= sat_add(parity_cnt, nfail);
          link_ok_r  <= 1'b0;
        end else begin
          link_ok_r  <= 1'b1;
        end
      end
      if (frame_err) begin
        frame_cnt <= sat_add(frame_cnt, 2'd1);
        link_ok_r <= 1'b0;
      end
      if (timeout) link_ok_r <= 1'b0;
    end
  end

  assign bus.setpoint       = sp_r;
  assign bus.sp_valid       = sp_valid_r;
  assign bus.link_ok        = link_ok_r;
  assign bus.frame_err_cnt  = frame_cnt;
  assign bus.parity_err_cnt = parity_cnt;
  assign bus.dbg_state      = state;

`ifdef XY2_STATUS_TX_EN
  logic [XY2_FRAME_LEN-1:0] status_sr;
  logic [15:0]              status_src;

  // A down link reports all-ones so the host can tell stale status apart.
  assign status_src = link_ok_r ? bus.status_word : 16'hFFFF;

  always_ff @(posedge clk_ref or negedge sys_rstn) begin
    if (!sys_rstn) status_sr <= '0;
    else if (start)
      status_sr <= {XY2_HDR_STD, status_src, ~xy2_even_parity({XY2_HDR_STD, status_src, 1'b0})};
    else if (clk_rise)
      status_sr <= {status_sr[XY2_FRAME_LEN-2:0], 1'b0};
  end

  assign bus.xy_status = status_sr[XY2_FRAME_LEN-1];
  assign unused_sig    = ^{clk_q, sync_rise, sync_fall, data_rise, data_fall};
`else
  assign bus.xy_status = 1'b0;
  assign unused_sig    = ^{clk_q, clk_rise, sync_rise, sync_fall, data_rise, data_fall, bus.status_word};
`endif

endmodule

// File: tb/tb_xy2_rx_multi.sv
// Directed bench for xy2_rx_multi: a 2-channel 16-bit receiver and a
// 1-channel 18-bit receiver share the XY2 clock and sync lines.
`timescale 1ns/1ps
module tb_xy2_rx_multi;
  import galvo_pkg::*;

  localparam logic [19:0] G1234     = {3'b001, 16'h1234, 1'b0};
  localparam logic [19:0] GBEEF     = {3'b001, 16'hBEEF, 1'b0};
  localparam logic [19:0] G0001     = {3'b001, 16'h0001, 1'b0};
  localparam logic [19:0] BBEEF_PAR = {3'b001, 16'hBEEF, 1'b1};
  localparam logic [19:0] B1234_PAR = {3'b001, 16'h1234, 1'b1};
  localparam logic [19:0] BBEEF_HDR = {3'b000, 16'hBEEF, 1'b1};
  localparam logic [19:0] G18_FF    = {1'b1, 18'h3FFFF, 1'b1};
  localparam logic [19:0] G18_01    = {1'b1, 18'h00001, 1'b0};
  localparam logic [19:0] B18_HDR   = {1'b0, 18'h3FFFF, 1'b0};

  logic clk_ref = 1'b0;
  logic sys_rstn = 1'b0;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   sp_cnt0 = 0, sp_cnt1 = 0, sp_cnt18 = 0;
  int   s0, s1, s18;
  int   last_sp_cyc = 0;
  int   fall20_cyc = 0;

  // clock/reset block
  always #25 clk_ref = ~clk_ref;
  always @(posedge clk_ref) cyc <= cyc + 1;

  xy2_rx_multi_if #(.NUM_CH(2), .DATA_W(16)) bus ();
  xy2_rx_multi_if #(.NUM_CH(1), .DATA_W(18)) bus18 ();

  xy2_rx_multi #(.NUM_CH(2), .DATA_W(16), .TIMEOUT_CYC(400)) u_dut (
    .clk_ref(clk_ref), .sys_rstn(sys_rstn), .bus(bus)
  );
  xy2_rx_multi #(.NUM_CH(1), .DATA_W(18), .TIMEOUT_CYC(400)) u_dut18 (
    .clk_ref(clk_ref), .sys_rstn(sys_rstn), .bus(bus18)
  );

  // strobe monitor
  always @(negedge clk_ref) begin
    if (bus.sp_valid[0]) sp_cnt0++;
    if (bus.sp_valid[1]) sp_cnt1++;
    if (bus18.sp_valid[0]) sp_cnt18++;
    if (bus.sp_valid != 2'b00) last_sp_cyc = cyc;
  end

  initial begin
    #(20000 * 50);
    $display("FAIL watchdog: simulation did not finish, cycle %0d required < 20000", cyc);
    $fatal(1, "watchdog expired");
  end

  // scoreboard check
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk_ref);
    #1;
  endtask

  task automatic drive_lines(input logic c, input logic s, input logic [1:0] d, input logic d18);
    bus.xy_clk      = c;
    bus18.xy_clk    = c;
    bus.xy_sync     = s;
    bus18.xy_sync   = s;
    bus.xy_data     = d;
    bus18.xy_data   = d18;
  endtask

  task automatic idle_clocks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1); drive_lines(1'b1, 1'b0, 2'b00, 1'b0);
      step(5); drive_lines(1'b0, 1'b0, 2'b00, 1'b0);
      step(4);
    end
  endtask

  // sync is high for bits 1..sync_low_from-1 (1-based), low from there on
  task automatic send_frames(input logic [19:0] fx, input logic [19:0] fy,
                             input logic [19:0] f18, input int sync_low_from);
    for (int b = 0; b < 20; b++) begin
      step(1);
      drive_lines(1'b1, (b + 1 < sync_low_from), {fy[19-b], fx[19-b]}, f18[19-b]);
      step(5);
      bus.xy_clk   = 1'b0;
      bus18.xy_clk = 1'b0;
      if (b == 19) fall20_cyc = cyc;
      step(4);
    end
    repeat (10) @(posedge clk_ref);
    @(negedge clk_ref);
  endtask

  task automatic snap();
    s0 = sp_cnt0; s1 = sp_cnt1; s18 = sp_cnt18;
  endtask

  initial begin
    bus.status_word   = 16'hA5A5;
    bus18.status_word = 16'hA5A5;
    drive_lines(1'b1, 1'b0, 2'b00, 1'b0);
    repeat (4) @(posedge clk_ref);
    @(negedge clk_ref);

    chk("rst_setpoint",   64'(bus.setpoint), 64'h8000_8000);
    chk("rst_setpoint18", 64'(bus18.setpoint), 64'h2_0000);
    chk("rst_sp_valid",   64'(bus.sp_valid), 64'h0);
    chk("rst_link_ok",    64'(bus.link_ok), 64'h0);
    chk("rst_frame_cnt",  64'(bus.frame_err_cnt), 64'h0);
    chk("rst_parity_cnt", 64'(bus.parity_err_cnt), 64'h0);
    chk("rst_xy_status",  64'(bus.xy_status), 64'h0);
    chk("rst_state",      64'(bus.dbg_state), 64'(ST_IDLE));

    step(1); sys_rstn = 1'b1;
    idle_clocks(2);

    // good frame on both channels
    snap();
    send_frames(G1234, GBEEF, G18_FF, 20);
    chk("t1_setpoint",   64'(bus.setpoint), 64'hBEEF_1234);
    chk("t1_pulses_x",   64'(sp_cnt0 - s0), 64'd1);
    chk("t1_pulses_y",   64'(sp_cnt1 - s1), 64'd1);
    chk("t1_latency_ok", 64'((last_sp_cyc - fall20_cyc) > 0 && (last_sp_cyc - fall20_cyc) <= 5), 64'd1);
    chk("t1_link_ok",    64'(bus.link_ok), 64'd1);
    chk("t1_parity_cnt", 64'(bus.parity_err_cnt), 64'd0);
    chk("t1_frame_cnt",  64'(bus.frame_err_cnt), 64'd0);
    chk("t1_setpoint18", 64'(bus18.setpoint), 64'h3_FFFF);

    // reset, then the first frame is gated until sync has been seen low
    step(1); sys_rstn = 1'b0;
    step(3);
    @(negedge clk_ref);
    chk("t2_rst_setpoint", 64'(bus.setpoint), 64'h8000_8000);
    chk("t2_rst_link",     64'(bus.link_ok), 64'd0);
    step(1); sys_rstn = 1'b1;
    snap();
    send_frames(G1234, GBEEF, G18_01, 20);
    chk("t2_gated_setpoint", 64'(bus.setpoint), 64'h8000_8000);
    chk("t2_gated_pulses",   64'(sp_cnt0 - s0 + sp_cnt1 - s1), 64'd0);
    chk("t2_gated_frame",    64'(bus.frame_err_cnt), 64'd0);

    // Y parity flipped
    snap();
    send_frames(G1234, BBEEF_PAR, G18_01, 20);
    chk("t2_setpoint",   64'(bus.setpoint), 64'h8000_1234);
    chk("t2_pulses_x",   64'(sp_cnt0 - s0), 64'd1);
    chk("t2_pulses_y",   64'(sp_cnt1 - s1), 64'd0);
    chk("t2_parity_cnt", 64'(bus.parity_err_cnt), 64'd1);
    chk("t2_link_ok",    64'(bus.link_ok), 64'd0);
    chk("t2_setpoint18", 64'(bus18.setpoint), 64'h0_0001);

    // sync dropped from bit 12 onward
    snap();
    send_frames(G1234, GBEEF, G18_01, 12);
    chk("t3_pulses",     64'(sp_cnt0 - s0 + sp_cnt1 - s1), 64'd0);
    chk("t3_frame_cnt",  64'(bus.frame_err_cnt), 64'd1);
    chk("t3_setpoint",   64'(bus.setpoint), 64'h8000_1234);
    send_frames(G0001, GBEEF, G18_01, 20);
    chk("t3_next_setpoint", 64'(bus.setpoint), 64'hBEEF_0001);
    chk("t3_next_link",     64'(bus.link_ok), 64'd1);
    chk("t3_next_frame",    64'(bus.frame_err_cnt), 64'd1);
    chk("t3_next_parity",   64'(bus.parity_err_cnt), 64'd1);

    // xy_clk stopped: link times out near 400 cycles after the last fall
    while (cyc < fall20_cyc + 390) @(negedge clk_ref);
    chk("t4_link_before", 64'(bus.link_ok), 64'd1);
    while (cyc < fall20_cyc + 420) @(negedge clk_ref);
    chk("t4_link_after",  64'(bus.link_ok), 64'd0);
    chk("t4_setpoint",    64'(bus.setpoint), 64'hBEEF_0001);
    chk("t4_state",       64'(bus.dbg_state), 64'(ST_IDLE));
    while (cyc < fall20_cyc + 500) @(negedge clk_ref);
    send_frames(G1234, GBEEF, G18_01, 20);
    chk("t4_restart_link",     64'(bus.link_ok), 64'd1);
    chk("t4_restart_setpoint", 64'(bus.setpoint), 64'hBEEF_1234);
    chk("t4_restart_link18",   64'(bus18.link_ok), 64'd1);

    // both 16-bit channels bad; 18-bit header cleared
    snap();
    send_frames(B1234_PAR, BBEEF_HDR, B18_HDR, 20);
    chk("t5_parity_cnt",   64'(bus.parity_err_cnt), 64'd3);
    chk("t5_setpoint",     64'(bus.setpoint), 64'hBEEF_1234);
    chk("t5_pulses",       64'(sp_cnt0 - s0 + sp_cnt1 - s1), 64'd0);
    chk("t5_parity18",     64'(bus18.parity_err_cnt), 64'd1);
    chk("t5_setpoint18",   64'(bus18.setpoint), 64'h0_0001);
    chk("t5_pulses18",     64'(sp_cnt18 - s18), 64'd0);
    chk("t5_link18",       64'(bus18.link_ok), 64'd0);
    chk("t5_frame18",      64'(bus18.frame_err_cnt), 64'd1);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/xy2_rx_multi.md
Name: xy2_rx_multi

Overview:
- Parametrised XY2-100 / XY2-100-E command receiver replacing the inline two-axis receive logic in the galvo top level.
- Receives NUM_CH serial channels (X, Y, optional Z) on a shared xy_clk/xy_sync pair, oversampled on clk_ref.
- Checks header and parity per channel, then publishes setpoints to the position PID.
- Adds link supervision, error counters and an optional status return channel.

Parameters:
- NUM_CH, 2: number of data channels, legal 1..3.
- DATA_W, 16: setpoint width; 16 = standard frame (3-bit header 3'b001), 18 = enhanced frame (1-bit header 1'b1).
- TIMEOUT_CYC, 400: clk_ref cycles without an xy_clk falling edge before the link is declared lost (20 us at 20 MHz).

Ports:
- clk_ref  in  1  oversampling clock, 20 MHz nominal.
- sys_rstn  in  1  asynchronous active-low reset.
- xy_clk  in  1  XY2 clock, 2 MHz; asynchronous to clk_ref.
- xy_sync  in  1  XY2 sync, asynchronous.
- xy_data  in  NUM_CH  serial data, bit 0 = X; asynchronous.
- status_word  in  16  word returned to host (feature only).
- xy_status  out  1  XY2 status line.
- setpoint  out  NUM_CH*DATA_W  latched setpoints, channel c at [c*DATA_W +: DATA_W].
- sp_valid  out  NUM_CH  1-cycle pulse per channel when its setpoint updates.
- link_ok  out  1  high while frames arrive error-free.
- frame_err_cnt  out  16  saturating count of framing errors.
- parity_err_cnt  out  16  saturating count of channel parity or header errors, all channels summed.

Behaviour:
- Reset: 2-flop synchronisers cleared; every setpoint channel = 1<<(DATA_W-1) (0x8000 at DATA_W=16); sp_valid=0; link_ok=0; both counters=0; xy_status=0; FSM=IDLE.
- Inputs: xy_clk, xy_sync and xy_data each pass through a 2-flop synchroniser. Edges are detected on the synchronised xy_clk; synchronised data and sync are sampled on the xy_clk falling edge.
- Frame format: 20 bits, MSB first = header (19-DATA_W bits), data (DATA_W), even parity over all 20 bits. xy_sync is high for bits 1..19 and low for bit 20.
- FSM states:
  - IDLE: on a falling edge with sync=1, shift bit 1 and set bit_cnt=1, go to SHIFT.
  - SHIFT: each falling edge shifts one bit per channel and increments bit_cnt.
    - sync=0 with bit_cnt==19 (bit 20 arriving): go to CHECK.
    - sync=0 earlier: framing error, go to IDLE.
    - sync=1 at bit_cnt==19: framing error, go to RESYNC.
  - CHECK (1 cycle): per channel, header matches and parity is even -> load setpoint and pulse sp_valid[c] on the same cycle. Otherwise count a parity error and leave that channel's setpoint unchanged. Go to IDLE.
  - RESYNC: wait for a falling edge with sync=0, then go to IDLE.
- Latency: sp_valid pulses at most 5 clk_ref cycles after the bit-20 falling edge on the pins.
- Counters: 16 bits, saturate at 0xFFFF and do not wrap. When several channels fail in one frame, parity_err_cnt is incremented by the number of failing channels (saturating).
- link_ok:
  - Set after a frame with no errors on any channel.
  - Cleared on any error.
  - Cleared when the idle counter reaches TIMEOUT_CYC; the idle counter resets on every xy_clk falling edge.
  - On timeout the FSM returns to IDLE and setpoints hold their last value.
- Reset mid-frame: all state returns to reset values immediately. The next frame start is only recognised after sync is seen low, i.e. the FSM starts in RESYNC-equivalent gating.

Optional Feature:
- Macro XY2_STATUS_TX_EN.
- Defined: on each IDLE->SHIFT transition, a 20-bit status frame is loaded: 3'b001, status_word, then even parity. xy_status presents the MSB and shifts one bit per xy_clk rising edge. If link_ok=0, status_word is replaced by 16'hFFFF.
- Not defined: xy_status tied to 0 and status_word unused.

Decomposition:
- Shared package galvo_pkg holds:
  - XY2_FRAME_LEN=20
  - XY2_HDR_STD=3'b001, XY2_HDR_ENH=1'b1
  - FSM state encodings
  - function xy2_even_parity
- One sub-module, xy2_sync_edge: 2-flop synchroniser plus falling/rising edge pulse, instanced for clock, sync and each data line.

Test Plan:
- NUM_CH=2, valid frames X=0x1234, Y=0xBEEF -> setpoint=0xBEEF1234, sp_valid=2'b11 once, link_ok=1, counters 0.
- Y parity bit flipped -> X updates, Y holds 0x8000, sp_valid=2'b01, parity_err_cnt=1, link_ok=0.
- Sync dropped at bit 12 -> no sp_valid, frame_err_cnt=1; next valid frame (X=0x0001) accepted.
- xy_clk stopped 500 cycles after a good frame -> link_ok falls at cycle 400, setpoint unchanged; restart plus a good frame -> link_ok=1.
- DATA_W=18, header 1'b1, X=18'h3FFFF -> setpoint=18'h3FFFF; the same frame with header 0 -> parity_err_cnt+1.
- With XY2_STATUS_TX_EN, status_word=0xA5A5, link up -> xy_status carries 001_A5A5_p (p=even) MSB-first on xy_clk rising edges; link lost -> carries 001_FFFF_p.
